snoop_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares the single coherence/snoop bus among the per-core cache controllers of the multicore cache system.
- Sits between the per-core cache controllers and the shared bus mux inside the chip wrapper.
- Grants one owner at a time and holds the grant until the owner signals completion.
- Forces release on a hold timeout and inserts one turnaround cycle between owners.

---
 rtl/snoop_arb_pkg.sv | 15 +
 rtl/snoop_bus_arbiter_rr_pick.sv | 37 +++
 rtl/snoop_bus_arbiter.sv | 101 ++++++++++
 tb/tb_snoop_bus_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_arb_pkg.sv
// Shared types and default sizing for the snoop-bus arbiter and its helpers.
package snoop_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        TURN
    } arb_state_e;

    localparam int unsigned DEF_NUM_CORES = 4;
    localparam int unsigned DEF_MAX_HOLD  = 15;

    typedef logic [$clog2(DEF_NUM_CORES)-1:0] core_id_t;

endpackage

// File: rtl/snoop_bus_arbiter_rr_pick.sv
// Round-robin pick: first set request bit at or above i_rr_ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_rr_ptr,
    output logic [$clog2(N)-1:0] o_sel,
    output logic                 o_any_req
);

    localparam int unsigned W = $clog2(N);

    int unsigned w_pos;
    logic [W-1:0] w_idx;
    logic         w_found;

    always_comb begin
        o_sel     = '0;
        o_any_req = |i_req;
        w_found   = 1'b0;
        w_pos     = 0;
        w_idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // Explicit wrap keeps non-power-of-2 core counts correct.
            w_pos = 32'(i_rr_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_idx = W'(w_pos);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                o_sel   = w_idx;
            end
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner arbitration for the shared snoop bus: hold until done or
// request drop, forced release on hold timeout, one turnaround cycle between owners.
module snoop_bus_arbiter
    import snoop_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES = DEF_NUM_CORES,
    parameter int unsigned MAX_HOLD  = DEF_MAX_HOLD
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CORES-1:0]         req,
    input  logic [NUM_CORES-1:0]         done,
    output logic [NUM_CORES-1:0]         grant,
    output logic [$clog2(NUM_CORES)-1:0] bus_owner,
    output logic                         bus_valid,
    output logic                         timeout_err
);

    localparam int unsigned ID_W = $clog2(NUM_CORES);
    localparam int unsigned HC_W = $clog2(MAX_HOLD + 1);

    arb_state_e           r_state;
    logic [NUM_CORES-1:0] r_grant;
    logic [ID_W-1:0]      r_owner;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [HC_W-1:0]      r_hold_cnt;
    logic                 r_valid;
    logic                 r_timeout;

    logic [ID_W-1:0]      w_sel;
    logic                 w_any_req;
    logic [NUM_CORES-1:0] w_sel_onehot;
    logic                 w_release;
    logic                 w_timeout;
    logic [ID_W-1:0]      w_next_ptr;

    rr_pick #(
        .N(NUM_CORES)
    ) u_pick (
        .i_req     (req),
        .i_rr_ptr  (r_rr_ptr),
        .o_sel     (w_sel),
        .o_any_req (w_any_req)
    );

    assign w_sel_onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << w_sel;

    // Only the owner's done/req bits matter; done wins over a coincident timeout.
    assign w_release  = (r_state == BUSY) && (done[r_owner] || !req[r_owner]);
    assign w_timeout  = (r_state == BUSY) && !w_release &&
                        (r_hold_cnt == HC_W'(MAX_HOLD - 1));
    assign w_next_ptr = (r_owner == ID_W'(NUM_CORES - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state    <= BUSY;
                        r_grant    <= w_sel_onehot;
                        r_owner    <= w_sel;
                        r_valid    <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (w_release || w_timeout) begin
                        r_state   <= TURN;
                        r_grant   <= '0;
                        r_valid   <= 1'b0;
                        r_rr_ptr  <= w_next_ptr;
                        r_timeout <= w_timeout;
                    end else if (r_hold_cnt != HC_W'(MAX_HOLD)) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                TURN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign bus_owner   = r_owner;
    assign bus_valid   = r_valid;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: per-cycle reference model plus directed scenarios.
module tb_snoop_bus_arbiter;

    localparam int NC = 4;
    localparam int MH = 15;

    logic          clock = 1'b0;
    logic          reset;
    logic [NC-1:0] req;
    logic [NC-1:0] done;
    logic [NC-1:0] grant;
    logic [1:0]    bus_owner;
    logic          bus_valid;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;

    snoop_bus_arbiter #(
        .NUM_CORES(NC),
        .MAX_HOLD (MH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .bus_owner   (bus_owner),
        .bus_valid   (bus_valid),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, how many edges it has held it,
    // whether the bus is in its post-release quiet cycle, and the fairness pointer.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_turn  = 0;
    bit m_to    = 0;

    function void m_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_turn  = 0;
        m_to    = 0;
    endfunction

    function void m_release(input bit by_timeout);
        m_ptr   = (m_owner + 1) % NC;
        m_owner = -1;
        m_turn  = 1;
        m_to    = by_timeout;
    endfunction

    function void m_step();
        bit found;
        int c;
        m_to = 0;
        if (m_owner >= 0) begin
            m_held++;
            if (done[m_owner] || !req[m_owner]) m_release(0);
            else if (m_held >= MH)              m_release(1);
        end else if (m_turn) begin
            m_turn = 0;
        end else begin
            found = 0;
            for (int i = 0; i < NC; i++) begin
                c = (m_ptr + i) % NC;
                if (!found && req[c]) begin
                    found   = 1;
                    m_owner = c;
                    m_held  = 0;
                end
            end
        end
    endfunction

    // Bus-activity history derived from observed outputs, used by directed scenarios.
    bit prev_v    = 0;
    bit have_prev = 0;
    int zero_run  = 0;
    int run_len   = 0;
    int last_len  = 0;
    int to_count  = 0;
    int gaps[$];

    always @(posedge clock) begin
        logic [NC-1:0] eg;
        if (reset) m_reset();
        else       m_step();
        #1;
        eg = (m_owner >= 0) ? NC'(1 << m_owner) : '0;
        chk("grant", 32'(grant), 32'(eg));
        chk("bus_valid", 32'(bus_valid), 32'(m_owner >= 0));
        if (m_owner >= 0) chk("bus_owner", 32'(bus_owner), 32'(m_owner));
        chk("timeout_err", 32'(timeout_err), 32'(m_to));
        chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        chk("valid_eq_or_grant", 32'(bus_valid), 32'(|grant));

        if (reset) begin
            prev_v = 0; have_prev = 0; zero_run = 0; run_len = 0;
        end else begin
            if (timeout_err) to_count++;
            if (bus_valid) begin
                if (!prev_v) begin
                    if (have_prev) gaps.push_back(zero_run);
                    run_len = 0;
                end
                run_len++;
            end else begin
                if (prev_v) begin
                    last_len  = run_len;
                    zero_run  = 0;
                    have_prev = 1;
                end
                zero_run++;
            end
            prev_v = bus_valid;
        end
    end

    task automatic wait_valid(input logic want, input int maxc, input string nm);
        int n = 0;
        while (bus_valid !== want && n < maxc) begin
            @(negedge clock);
            n++;
        end
        chk(nm, 32'(bus_valid), 32'(want));
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int got[5];
        int to0;
        reset = 1'b1;
        req   = '0;
        done  = '0;
        repeat (2) @(negedge clock);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_owner", 32'(bus_owner), 32'h0);
        chk("rst_valid", 32'(bus_valid), 32'h0);
        chk("rst_timeout", 32'(timeout_err), 32'h0);
        reset = 1'b0;

        // Single requester.
        @(negedge clock); req = 4'b0100;
        @(negedge clock);
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_owner", 32'(bus_owner), 32'd2);
        chk("single_valid", 32'(bus_valid), 32'd1);
        @(negedge clock); done = 4'b0100;
        @(negedge clock); done = '0; req = '0;
        chk("single_release", 32'(grant), 32'h0);
        @(negedge clock);
        chk("single_turn", 32'(grant), 32'h0);
        repeat (3) @(negedge clock);

        // Full contention from a fresh pointer.
        pulse_reset();
        gaps.delete();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_valid(1'b1, 10, "cont_wait_grant");
            got[g] = int'(bus_owner);
            repeat (2) @(negedge clock);
            done = NC'(1 << got[g]);
            @(negedge clock);
            done = '0;
        end
        req = '0;
        chk("cont_order0", 32'(got[0]), 32'd0);
        chk("cont_order1", 32'(got[1]), 32'd1);
        chk("cont_order2", 32'(got[2]), 32'd2);
        chk("cont_order3", 32'(got[3]), 32'd3);
        chk("cont_order4", 32'(got[4]), 32'd0);
        chk("cont_gap_count", 32'(gaps.size()), 32'd4);
        foreach (gaps[i]) chk("cont_gap_len", 32'(gaps[i]), 32'd2);
        wait_valid(1'b0, 20, "cont_idle");
        repeat (3) @(negedge clock);

        // Hold timeout on core 1.
        to_count = 0;
        req = 4'b0010;
        wait_valid(1'b1, 10, "to_wait_grant");
        chk("to_owner", 32'(bus_owner), 32'd1);
        wait_valid(1'b0, 20, "to_wait_release");
        chk("to_hold_len", 32'(last_len), 32'd15);
        chk("to_pulse_count", 32'(to_count), 32'd1);
        wait_valid(1'b1, 10, "to_wait_regrant");
        chk("to_regrant_owner", 32'(bus_owner), 32'd1);
        chk("to_regrant_gap", 32'(gaps[$]), 32'd2);
        req = '0;
        wait_valid(1'b0, 5, "to_drop_release");
        chk("to_no_extra_pulse", 32'(to_count), 32'd1);
        repeat (3) @(negedge clock);

        // Stray done bits from non-owners, plus new requests, leave core 0's grant alone.
        req = 4'b0001;
        wait_valid(1'b1, 10, "stray_wait_grant");
        chk("stray_owner0", 32'(grant), 32'h1);
        done = 4'b1000;
        @(negedge clock); done = 4'b0010; req = 4'b0011;
        @(negedge clock); done = '0;
        chk("stray_grant_kept", 32'(grant), 32'h1);
        @(negedge clock); done = 4'b0001;
        @(negedge clock); done = '0;
        chk("stray_release", 32'(grant), 32'h0);
        wait_valid(1'b1, 10, "stray_next_grant");
        chk("stray_next_owner", 32'(bus_owner), 32'd1);

        // Request drop by core 3 hands the bus to pending core 0 (pointer wrap).
        req = 4'b1001;
        wait_valid(1'b0, 5, "drop1_release");
        wait_valid(1'b1, 10, "drop_wait_owner3");
        chk("drop_owner3", 32'(bus_owner), 32'd3);
        to0 = to_count;
        @(negedge clock); req = 4'b0001;
        @(negedge clock);
        chk("drop_release_next", 32'(bus_valid), 32'd0);
        wait_valid(1'b1, 10, "drop_wait_owner0");
        chk("drop_wrap_owner0", 32'(bus_owner), 32'd0);
        chk("drop_no_timeout", 32'(to_count), 32'(to0));
        req = '0;
        wait_valid(1'b0, 5, "drop_idle");
        repeat (3) @(negedge clock);

        // Asynchronous reset while core 2 owns the bus.
        req = 4'b0100;
        wait_valid(1'b1, 10, "arst_wait_grant");
        chk("arst_pre_grant", 32'(grant), 32'h4);
        #2 reset = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_valid", 32'(bus_valid), 32'h0);
        chk("arst_timeout", 32'(timeout_err), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        req   = 4'b1111;
        wait_valid(1'b1, 10, "arst_wait_regrant");
        chk("arst_first_owner", 32'(bus_owner), 32'd0);
        chk("arst_first_grant", 32'(grant), 32'h1);
        req = '0;
        wait_valid(1'b0, 5, "arst_idle");

        // Randomized traffic against the reference model.
        pulse_reset();
        for (int n = 0; n < 800; n++) begin
            @(negedge clock);
            for (int b = 0; b < NC; b++) begin
                if (!req[b]) req[b] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 15) == 0) req[b] = 1'b0;
            end
            done = ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0;
        end
        @(negedge clock);
        req  = '0;
        done = '0;
        repeat (25) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
